// File: rtl/led_uart_tx_if.sv
// Write-side and line-side signals of the LED UART transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: full tells the writer to hold off; writes while full are dropped and flagged.
interface led_uart_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       overflow;
    logic       busy;
    logic       tx;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  overflow,
        input  busy,
        input  tx
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output overflow,
        output busy,
        output tx
    );
endinterface

// File: rtl/led_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO written from a CPU store strobe.
// Latency: write into empty FIFO while idle -> start bit on the next edge; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: registered full; a write while full is dropped and sets sticky overflow.
module led_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic         clk,
    input  logic         rst,
    led_uart_tx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               pop;

    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [PTR_W:0]     count_q, count_d;
    logic               full_q, ovf_q;
    logic               wr_acc;
    logic               bit_end;
    logic               not_empty;

    // A write is taken only when the registered full flag is clear, regardless of a same-cycle pop.
    assign wr_acc    = bus.wr_en && !full_q;
    assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign not_empty = (count_q != '0);

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)    rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == (PTR_W+1)'(DEPTH));
            if (bus.wr_en && full_q) ovf_q <= 1'b1;
        end
    end

    // Transmit FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic. The shift register is loaded at pop time, so later writes cannot disturb
    // the byte in flight; a pop at the end of STOP chains frames with no idle gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (not_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    if (not_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != IDLE) || not_empty;

endmodule

// File: tb/tb_led_uart_tx.sv
// Bench for led_uart_tx at CLKS_PER_BIT=4, DEPTH=4.
// Latency: expected bytes queued at write time, frames decoded off tx by a monitor.
// Backpressure: writes expected to be dropped are never queued.
module tb_led_uart_tx;

    localparam int CPB = 4;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    led_uart_tx_if bus ();

    led_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one write strobe; queue the byte only if it should be transmitted.
    task automatic wr(input logic [7:0] b, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accept) exp_q.push_back(b);
        sync();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && bus.busy; i++) @(negedge clk);
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_last_stop_cycle(input int s);
        for (int i = 0; i < 500 && cyc != s + 4*CPB*10/4 - 1; i++) sync();
        check("align_stop", cyc, s + 10*CPB - 1);
    endtask

    task automatic wait_frame_start();
        for (int i = 0; i < 200 && starts.size() == 0; i++) @(negedge clk);
        check("frame_started", (starts.size() > 0) ? 1 : 0, 1);
        sync();
    endtask

    // Monitor: decode each frame from tx and compare against the scoreboard queue.
    initial begin : monitor
        logic [9:0] got;
        bit         stable;
        bit         aborted;
        logic [7:0] e;
        @(negedge clk);
        forever begin
            if (!rst && bus.tx === 1'b0) begin
                starts.push_back(cyc);
                got     = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) got[b] = bus.tx;
                            else if (bus.tx !== got[b]) stable = 1'b0;
                            @(negedge clk);
                        end
                    end
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", 32'(got), 32'({1'b1, e, 1'b0}));
                        check("bit_stable", 32'(stable), 1);
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int s;
        int n;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) sync();
        @(negedge clk);
        check("rst_tx", 32'(bus.tx), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        sync();
        rst = 1'b0;
        repeat (5) sync();
        check("hold_tx", 32'(bus.tx), 1);
        check("hold_busy", 32'(bus.busy), 0);

        // Single byte 0xA5: start bit one edge after the write, busy for 40 cycles from tx fall.
        starts.delete();
        wr(8'hA5, 1);
        @(negedge clk);
        check("lat_pre_tx", 32'(bus.tx), 1);
        check("lat_pre_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("lat_tx_low", 32'(bus.tx), 0);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 10*CPB);
        repeat (3) @(negedge clk);

        // Three back-to-back writes: contiguous frames, 120 cycles, order kept.
        starts.delete();
        sync();
        wr(8'h01, 1);
        wr(8'h02, 1);
        wr(8'h03, 1);
        wait_idle();
        check("b2b_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("b2b_gap1", starts[1] - starts[0], 10*CPB);
            check("b2b_gap2", starts[2] - starts[1], 10*CPB);
        end

        // Six writes: first pops, four fill the FIFO, sixth dropped.
        starts.delete();
        sync();
        wr(8'h10, 1);
        wr(8'h21, 1);
        wr(8'h32, 1);
        wr(8'h43, 1);
        wr(8'h54, 1);
        wr(8'h65, 0);
        @(negedge clk);
        check("ovfl_full", 32'(bus.full), 1);
        check("ovfl_flag", 32'(bus.overflow), 1);
        wait_idle();
        check("ovfl_frames", starts.size(), 5);
        check("ovfl_sticky", 32'(bus.overflow), 1);
        check("ovfl_full_clr", 32'(bus.full), 0);

        // Reset mid-frame with two bytes queued; write during reset ignored.
        starts.delete();
        sync();
        wr(8'h11, 1);
        wr(8'h22, 1);
        wr(8'h33, 1);
        repeat (12) sync();
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;
        sync();
        bus.wr_en   = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", 32'(bus.tx), 1);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_full", 32'(bus.full), 0);
        check("mid_rst_ovf", 32'(bus.overflow), 0);
        sync();
        rst = 1'b0;
        exp_q.delete();
        starts.delete();
        repeat (100) sync();
        check("post_rst_frames", starts.size(), 0);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_tx", 32'(bus.tx), 1);

        // Write on the last STOP cycle with an empty FIFO: one idle cycle, then the new frame.
        starts.delete();
        sync();
        wr(8'h3C, 1);
        wait_frame_start();
        s = starts[0];
        wait_last_stop_cycle(s);
        wr(8'h5A, 1);
        wait_idle();
        check("stop_wr_frames", starts.size(), 2);
        if (starts.size() == 2) check("stop_wr_gap", starts[1] - starts[0], 10*CPB + 1);

        // Three queued, write coincides with pop: count stays 3, one more write fills it.
        starts.delete();
        sync();
        wr(8'hA1, 1);
        wr(8'hB2, 1);
        wr(8'hC3, 1);
        wr(8'hD4, 1);
        wait_frame_start();
        s = starts[0];
        wait_last_stop_cycle(s);
        wr(8'hE5, 1);
        @(negedge clk);
        check("pushpop_full", 32'(bus.full), 0);
        check("pushpop_ovf", 32'(bus.overflow), 0);
        sync();
        wr(8'hF6, 1);
        @(negedge clk);
        check("pushpop_fill", 32'(bus.full), 1);
        check("pushpop_ovf2", 32'(bus.overflow), 0);
        wait_idle();
        check("pushpop_frames", starts.size(), 6);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
